// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, PCSrc encodings and the default reset PC
//   Shared by fetch_unit and control_unit.
package mips_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_BAD    = 2'b11
   } pcsrc_e;
endpackage

// File: rtl/en_flop.sv
// en_flop: register with enable and synchronous active-high reset to RST
//   clk, rst : clock, sync reset (active high)
//   en       : load d when high
//   d / q    : W-bit data in / registered out
module en_flop #(
   parameter int W = 32,
   parameter logic [W-1:0] RST = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk)
      if (rst) q <= RST;
      else if (en) q <= d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR/MDR/ALUOut registers, memory address mux, next-PC logic, IR decode
//   clk, reset            : clock, sync active-high reset
//   IorD                  : memory address select (0 PC, 1 ALUOut)
//   IRWrite, PCWrite      : IR load, unconditional PC load
//   Branch, Zero          : conditional PC load when both high
//   PCSrc                 : next-PC source (ALUResult, ALUOut, jump target; 11 illegal)
//   ALUResult, MemRD      : ALU result, memory read data
//   PC, Adr, Instr, Data, ALUOut : architectural/datapath registers and address
//   Opcode..SignImm       : decoded IR fields
//   instr_cnt, cycle_cnt  : debug counters
//   pcsrc_err, misalign   : sticky fault flags, cleared by reset only
module fetch_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 IorD,
   input  logic                 IRWrite,
   input  logic                 PCWrite,
   input  logic                 Branch,
   input  logic [1:0]           PCSrc,
   input  logic                 Zero,
   input  logic [WIDTH-1:0]     ALUResult,
   input  logic [WIDTH-1:0]     MemRD,
   output logic [WIDTH-1:0]     PC,
   output logic [WIDTH-1:0]     Adr,
   output logic [WIDTH-1:0]     Instr,
   output logic [5:0]           Opcode,
   output logic [5:0]           Funct,
   output logic [4:0]           Rs,
   output logic [4:0]           Rt,
   output logic [4:0]           Rd,
   output logic [WIDTH-1:0]     SignImm,
   output logic [WIDTH-1:0]     Data,
   output logic [WIDTH-1:0]     ALUOut,
   output logic [CNT_WIDTH-1:0] instr_cnt,
   output logic [CNT_WIDTH-1:0] cycle_cnt,
   output logic                 pcsrc_err,
   output logic                 misalign
);
   pcsrc_e           src;
   logic             pc_en;
   logic             pc_load;
   logic [WIDTH-1:0] pc_next;
   assign src = pcsrc_e'(PCSrc);
   // An illegal source suppresses the load so PC holds rather than taking garbage.
   always_comb begin
      pc_en   = PCWrite | (Branch & Zero);
      pc_load = pc_en & (src != PCSRC_BAD);
      pc_next = src == PCSRC_ALU    ? ALUResult :
                src == PCSRC_ALUOUT ? ALUOut    :
                {PC[WIDTH-1:28], Instr[25:0], 2'b00};
   end
   en_flop #(.W(WIDTH), .RST(RESET_PC)) u_pc (
      .clk(clk), .rst(reset), .en(pc_load), .d(pc_next), .q(PC)
   );
   en_flop #(.W(WIDTH)) u_ir (
      .clk(clk), .rst(reset), .en(IRWrite), .d(MemRD), .q(Instr)
   );
   en_flop #(.W(WIDTH)) u_mdr (
      .clk(clk), .rst(reset), .en(1'b1), .d(MemRD), .q(Data)
   );
   en_flop #(.W(WIDTH)) u_aluout (
      .clk(clk), .rst(reset), .en(1'b1), .d(ALUResult), .q(ALUOut)
   );
   assign Adr     = IorD ? ALUOut : PC;
   assign Opcode  = Instr[31:26];
   assign Rs      = Instr[25:21];
   assign Rt      = Instr[20:16];
   assign Rd      = Instr[15:11];
   assign Funct   = Instr[5:0];
   assign SignImm = {{(WIDTH-16){Instr[15]}}, Instr[15:0]};
   always_ff @(posedge clk)
      if (reset) begin
         instr_cnt <= '0;
         cycle_cnt <= '0;
         pcsrc_err <= 1'b0;
         misalign  <= 1'b0;
      end else begin
         instr_cnt <= instr_cnt + CNT_WIDTH'(IRWrite);
         cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
         pcsrc_err <= pcsrc_err | (pc_en & (src == PCSRC_BAD));
         misalign  <= misalign | (pc_load & (pc_next[1:0] != 2'b00));
      end
endmodule
